// File: rtl/atm_pkg.sv
// Shared constants and FSM encoding for the ATM keypad transaction sequencer.
// Key codes, ATM_design select codes and the success result code live here.
package atm_pkg;

    localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
    localparam logic [3:0] KEY_ENTER     = 4'd10;
    localparam logic [3:0] KEY_CLEAR     = 4'd11;
    localparam logic [3:0] KEY_CANCEL    = 4'd12;
    localparam logic [3:0] SEL_MAX_DIGIT = 4'd3;

    localparam logic [1:0] SEL_EXIT = 2'd0;
    localparam logic [1:0] SEL_BAL  = 2'd1;
    localparam logic [1:0] SEL_WDR  = 2'd2;
    localparam logic [1:0] SEL_XFR  = 2'd3;

    localparam logic [1:0] RESULT_OK = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_GET_SEL = 4'd1,
        S_GET_SRC = 4'd2,
        S_GET_DST = 4'd3,
        S_GET_AMT = 4'd4,
        S_ISSUE   = 4'd5,
        S_WAIT    = 4'd6,
        S_DONE    = 4'd7,
        S_LOCKED  = 4'd8
    } state_t;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= KEY_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/atm_digit_acc.sv
// Decimal entry accumulator: acc = acc*10 + digit, refused when the result would
// exceed limit_i. One instance is shared by every numeric entry field.
module atm_digit_acc #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [3:0]       digit_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             overflow_o
);

    localparam int unsigned EW = WIDTH + 4;

    logic [WIDTH-1:0] acc_q;
    logic [EW-1:0]    ext;

    // Four extra bits hold acc*10+9 for any acc that fits in WIDTH bits.
    always_comb begin
        ext        = EW'(acc_q) * EW'(10) + EW'(digit_i);
        overflow_o = ext > EW'(limit_i);
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            acc_q <= '0;
        end else if (load_i && !overflow_o) begin
            acc_q <= ext[WIDTH-1:0];
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/atm_txn_sequencer.sv
// Keypad front end for ATM_design: collects menu, accounts and amount, issues the
// request, samples the result after a fixed latency and locks after repeated failures.
module atm_txn_sequencer
    import atm_pkg::*;
#(
    parameter int unsigned ATM_LAT  = 1,
    parameter int unsigned TIMEOUT  = 1000,
    parameter int unsigned MAX_FAIL = 3,
    parameter int unsigned ACC_W    = 4,
    parameter int unsigned AMT_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic [1:0]       atm_select,
    output logic [ACC_W-1:0] atm_acc_s,
    output logic [ACC_W-1:0] atm_acc_d,
    output logic [AMT_W-1:0] atm_amount,
    output logic             atm_req,
    input  logic [1:0]       atm_result,
    input  logic [AMT_W-1:0] atm_balance,
    output logic             busy,
    output logic             done,
    output logic             ok,
    output logic [AMT_W-1:0] disp_value,
    output logic             err,
    output logic             timeout,
    output logic             locked
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned FW = $clog2(MAX_FAIL + 1);
    localparam int unsigned LW = $clog2(ATM_LAT + 1);
    localparam logic [AMT_W-1:0] ACC_LIMIT = AMT_W'((2 ** ACC_W) - 1);
    localparam logic [AMT_W-1:0] AMT_LIMIT = '1;

    state_t           state_q;
    logic [1:0]       sel_q;
    logic             sel_vld_q;
    logic [TW-1:0]    timer_q;
    logic [FW-1:0]    fail_q;
    logic [LW-1:0]    lat_q;
    logic [1:0]       select_q;
    logic [ACC_W-1:0] acc_s_q;
    logic [ACC_W-1:0] acc_d_q;
    logic [AMT_W-1:0] amount_q;
    logic [AMT_W-1:0] disp_q;
    logic             req_q;
    logic             done_q;
    logic             ok_q;
    logic             err_q;
    logic             timeout_q;
    logic             locked_q;

    logic [AMT_W-1:0] acc_val;
    logic [AMT_W-1:0] acc_limit;
    logic             acc_ovf;
    logic             acc_load;
    logic             acc_clear;
    logic             in_entry;
    logic             in_get;
    logic             is_dig;
    logic             tmo_hit;
    logic             abort;

    always_comb begin
        in_entry  = state_q inside {S_GET_SRC, S_GET_DST, S_GET_AMT};
        in_get    = in_entry || (state_q == S_GET_SEL);
        is_dig    = is_digit(key_code);
        tmo_hit   = in_get && !key_valid && (timer_q == TW'(TIMEOUT - 1));
        abort     = tmo_hit || (in_get && key_valid && (key_code == KEY_CANCEL));
        acc_limit = (state_q == S_GET_AMT) ? AMT_LIMIT : ACC_LIMIT;
        acc_load  = in_entry && key_valid && is_dig;
        acc_clear = abort || (in_entry && key_valid &&
                              (key_code == KEY_ENTER || key_code == KEY_CLEAR));
    end

    atm_digit_acc #(.WIDTH(AMT_W)) u_acc (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (acc_clear),
        .load_i     (acc_load),
        .digit_i    (key_code),
        .limit_i    (acc_limit),
        .acc_o      (acc_val),
        .overflow_o (acc_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            sel_vld_q <= 1'b0;
            timer_q   <= '0;
            fail_q    <= '0;
            lat_q     <= '0;
            select_q  <= '0;
            acc_s_q   <= '0;
            acc_d_q   <= '0;
            amount_q  <= '0;
            disp_q    <= '0;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            timer_q   <= (!in_get || key_valid || tmo_hit) ? '0 : timer_q + 1'b1;

            if (abort) begin
                // Timeout and CANCEL share one exit path; only the pulse differs.
                state_q   <= S_IDLE;
                timeout_q <= tmo_hit;
                sel_q     <= '0;
                sel_vld_q <= 1'b0;
                select_q  <= '0;
                acc_s_q   <= '0;
                acc_d_q   <= '0;
                amount_q  <= '0;
                disp_q    <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (key_valid && key_code == KEY_ENTER) begin
                            state_q   <= S_GET_SEL;
                            ok_q      <= 1'b0;
                            disp_q    <= '0;
                            sel_vld_q <= 1'b0;
                            select_q  <= '0;
                            acc_s_q   <= '0;
                            acc_d_q   <= '0;
                            amount_q  <= '0;
                        end
                    end
                    S_GET_SEL: begin
                        if (key_valid) begin
                            if (is_dig) begin
                                if (key_code <= SEL_MAX_DIGIT) begin
                                    sel_q     <= key_code[1:0];
                                    sel_vld_q <= 1'b1;
                                    disp_q    <= AMT_W'(key_code);
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end else if (key_code == KEY_ENTER) begin
                                if (!sel_vld_q) begin
                                    err_q <= 1'b1;
                                end else begin
                                    select_q <= sel_q;
                                    if (sel_q == SEL_EXIT) begin
                                        state_q <= S_DONE;
                                        done_q  <= 1'b1;
                                        ok_q    <= 1'b1;
                                        disp_q  <= '0;
                                    end else begin
                                        state_q <= S_GET_SRC;
                                    end
                                end
                            end else if (key_code == KEY_CLEAR) begin
                                sel_vld_q <= 1'b0;
                                disp_q    <= '0;
                            end
                        end
                    end
                    S_GET_SRC: begin
                        if (key_valid && is_dig && acc_ovf) begin
                            err_q <= 1'b1;
                        end else if (key_valid && key_code == KEY_ENTER) begin
                            acc_s_q <= acc_val[ACC_W-1:0];
                            if (select_q == SEL_XFR) begin
                                state_q <= S_GET_DST;
                            end else if (select_q == SEL_WDR) begin
                                state_q <= S_GET_AMT;
                            end else begin
                                state_q <= S_ISSUE;
                                req_q   <= 1'b1;
                            end
                        end
                    end
                    S_GET_DST: begin
                        if (key_valid && is_dig && acc_ovf) begin
                            err_q <= 1'b1;
                        end else if (key_valid && key_code == KEY_ENTER) begin
                            acc_d_q <= acc_val[ACC_W-1:0];
                            state_q <= S_GET_AMT;
                        end
                    end
                    S_GET_AMT: begin
                        if (key_valid && is_dig && acc_ovf) begin
                            err_q <= 1'b1;
                        end else if (key_valid && key_code == KEY_ENTER) begin
                            amount_q <= acc_val;
                            state_q  <= S_ISSUE;
                            req_q    <= 1'b1;
                        end
                    end
                    S_ISSUE: begin
                        lat_q   <= '0;
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (lat_q == LW'(ATM_LAT - 1)) begin
                            req_q   <= 1'b0;
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            if (select_q == SEL_BAL) begin
                                ok_q   <= 1'b1;
                                disp_q <= atm_balance;
                                fail_q <= '0;
                            end else if (atm_result == RESULT_OK) begin
                                ok_q   <= 1'b1;
                                disp_q <= amount_q;
                                fail_q <= '0;
                            end else begin
                                ok_q   <= 1'b0;
                                disp_q <= atm_balance;
                                if (fail_q != FW'(MAX_FAIL)) begin
                                    fail_q <= fail_q + 1'b1;
                                end
                            end
                        end else begin
                            lat_q <= lat_q + 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (fail_q == FW'(MAX_FAIL)) begin
                            state_q  <= S_LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_LOCKED: begin
                        state_q <= S_LOCKED;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign atm_select = select_q;
    assign atm_acc_s  = acc_s_q;
    assign atm_acc_d  = acc_d_q;
    assign atm_amount = amount_q;
    assign atm_req    = req_q;
    assign busy       = !(state_q == S_IDLE || state_q == S_LOCKED);
    assign done       = done_q;
    assign ok         = ok_q;
    assign disp_value = in_entry ? acc_val : disp_q;
    assign err        = err_q;
    assign timeout    = timeout_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_atm_txn_sequencer.sv
// Self-checking bench for atm_txn_sequencer: directed scenarios plus randomized
// withdraw/transfer sessions against a behavioural outcome and lockout model.
module tb_atm_txn_sequencer;

    localparam int TMO   = 40;
    localparam int LAT   = 3;
    localparam int ACC_W = 4;
    localparam int AMT_W = 10;
    localparam int MAXF  = 3;

    localparam logic [3:0] K_ENT = 4'd10;
    localparam logic [3:0] K_CLR = 4'd11;
    localparam logic [3:0] K_CAN = 4'd12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             key_valid = 1'b0;
    logic [3:0]       key_code = 4'd0;
    logic [1:0]       atm_result = 2'd0;
    logic [AMT_W-1:0] atm_balance = '0;
    logic [1:0]       atm_select;
    logic [ACC_W-1:0] atm_acc_s;
    logic [ACC_W-1:0] atm_acc_d;
    logic [AMT_W-1:0] atm_amount;
    logic             atm_req;
    logic             busy;
    logic             done;
    logic             ok;
    logic [AMT_W-1:0] disp_value;
    logic             err;
    logic             timeout;
    logic             locked;

    int errors = 0;
    int checks = 0;

    atm_txn_sequencer #(
        .ATM_LAT(LAT), .TIMEOUT(TMO), .MAX_FAIL(MAXF), .ACC_W(ACC_W), .AMT_W(AMT_W)
    ) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .atm_select(atm_select), .atm_acc_s(atm_acc_s), .atm_acc_d(atm_acc_d),
        .atm_amount(atm_amount), .atm_req(atm_req), .atm_result(atm_result),
        .atm_balance(atm_balance), .busy(busy), .done(done), .ok(ok),
        .disp_value(disp_value), .err(err), .timeout(timeout), .locked(locked)
    );

    always #5 clk = ~clk;

    // Observed events, sampled on the falling edge.
    int               err_cnt = 0;
    int               tmo_cnt = 0;
    int               done_cnt = 0;
    int               req_cyc = 0;
    int               unstable = 0;
    int               overlap = 0;
    logic             req_prev = 1'b0;
    logic             last_ok = 1'b0;
    logic [AMT_W-1:0] last_disp = '0;
    logic [1:0]       cap_sel = '0;
    logic [ACC_W-1:0] cap_s = '0;
    logic [ACC_W-1:0] cap_d = '0;
    logic [AMT_W-1:0] cap_amt = '0;

    always @(negedge clk) begin
        if (err) err_cnt++;
        if (timeout) tmo_cnt++;
        if (err && timeout) overlap++;
        if (done) begin
            done_cnt++;
            last_ok = ok;
            last_disp = disp_value;
        end
        if (atm_req) begin
            req_cyc++;
            if (!req_prev) begin
                cap_sel = atm_select;
                cap_s   = atm_acc_s;
                cap_d   = atm_acc_d;
                cap_amt = atm_amount;
            end else if (atm_select != cap_sel || atm_acc_s != cap_s ||
                         atm_acc_d != cap_d || atm_amount != cap_amt) begin
                unstable++;
            end
        end
        req_prev = atm_req;
    end

    logic [AMT_W:0] exp_q[$];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code = k;
        step();
        key_valid = 1'b0;
        key_code = 4'($urandom_range(0, 15));
        step();
    endtask

    task automatic enter_num(input int v);
        int d[$];
        int t;
        t = v;
        if (!(v == 0 && $urandom_range(0, 1) == 1)) begin
            do begin
                d.push_front(t % 10);
                t = t / 10;
            end while (t > 0);
        end
        foreach (d[i]) press(4'(d[i]));
        press(K_ENT);
    endtask

    task automatic wait_done(input int base, output bit got);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            if (done_cnt > base) got = 1'b1;
        end
    endtask

    task automatic run_session(input int sel, input int src, input int dst, input int amt,
                               input int res, input int bal, output bit got);
        int base;
        base = done_cnt;
        atm_result = 2'(res);
        atm_balance = AMT_W'(bal);
        press(K_ENT);
        press(4'(sel));
        press(K_ENT);
        if (sel != 0) enter_num(src);
        if (sel == 3) enter_num(dst);
        if (sel >= 2) enter_num(amt);
        wait_done(base, got);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (atm_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", atm_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if ({done, ok, err, timeout, locked} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {done, ok, err, timeout, locked}); end
        checks++; if ({atm_select, atm_acc_s, atm_acc_d, atm_amount, disp_value} !== '0) begin
            errors++; $display("FAIL reset_fields: got nonzero sel=%0d s=%0d d=%0d amt=%0d disp=%0d want 0",
                               atm_select, atm_acc_s, atm_acc_d, atm_amount, disp_value); end
    endtask

    task automatic test_balance();
        bit got;
        int r0;
        r0 = req_cyc;
        run_session(1, 4, 0, 0, 0, 300, got);
        checks++; if (!got) begin errors++; $display("FAIL t1_done: got none want pulse"); end
        checks++; if (cap_sel !== 2'd1 || cap_s !== 4'd4) begin
            errors++; $display("FAIL t1_fields: got sel=%0d s=%0d want sel=1 s=4", cap_sel, cap_s); end
        checks++; if (last_ok !== 1'b1 || last_disp !== 10'd300) begin
            errors++; $display("FAIL t1_outcome: got ok=%0b disp=%0d want ok=1 disp=300", last_ok, last_disp); end
        checks++; if (req_cyc - r0 < 1 || req_cyc - r0 > LAT + 1) begin
            errors++; $display("FAIL t1_req_len: got %0d want 1..%0d", req_cyc - r0, LAT + 1); end
        checks++; if (atm_req !== 1'b0 || busy !== 1'b0 || ok !== 1'b1) begin
            errors++; $display("FAIL t1_after: got req=%0b busy=%0b ok=%0b want 0 0 1", atm_req, busy, ok); end
    endtask

    task automatic test_transfer();
        bit got;
        run_session(3, 6, 10, 40, 3, 500, got);
        checks++; if (!got) begin errors++; $display("FAIL t2_done: got none want pulse"); end
        checks++; if (cap_sel !== 2'd3 || cap_s !== 4'd6 || cap_d !== 4'd10 || cap_amt !== 10'd40) begin
            errors++; $display("FAIL t2_fields: got sel=%0d s=%0d d=%0d amt=%0d want 3 6 10 40",
                               cap_sel, cap_s, cap_d, cap_amt); end
        checks++; if (last_ok !== 1'b1 || last_disp !== 10'd40) begin
            errors++; $display("FAIL t2_outcome: got ok=%0b disp=%0d want ok=1 disp=40", last_ok, last_disp); end
    endtask

    task automatic test_entry_errors();
        bit got;
        int e0;
        int base;
        e0 = err_cnt;
        press(K_ENT);
        press(K_ENT);
        press(4'd7);
        press(K_CAN);
        checks++; if (err_cnt - e0 != 2 || busy !== 1'b0) begin
            errors++; $display("FAIL t3_sel_err: got errs=%0d busy=%0b want 2 0", err_cnt - e0, busy); end
        e0 = err_cnt;
        base = done_cnt;
        atm_result = 2'd3;
        atm_balance = 10'd900;
        press(K_ENT); press(4'd2); press(K_ENT);
        press(4'd1); press(4'd6);
        checks++; if (err_cnt - e0 != 1 || disp_value !== 10'd1) begin
            errors++; $display("FAIL t3_src_ovf: got errs=%0d disp=%0d want 1 1", err_cnt - e0, disp_value); end
        press(K_ENT);
        press(4'd1); press(4'd0); press(4'd2);
        checks++; if (err_cnt - e0 != 1 || disp_value !== 10'd102) begin
            errors++; $display("FAIL t3_amt_pre: got errs=%0d disp=%0d want 1 102", err_cnt - e0, disp_value); end
        press(4'd4);
        checks++; if (err_cnt - e0 != 2 || disp_value !== 10'd102) begin
            errors++; $display("FAIL t3_amt_ovf: got errs=%0d disp=%0d want 2 102", err_cnt - e0, disp_value); end
        press(K_ENT);
        wait_done(base, got);
        checks++; if (!got || cap_s !== 4'd1 || cap_amt !== 10'd102 || last_disp !== 10'd102) begin
            errors++; $display("FAIL t3_commit: got done=%0b s=%0d amt=%0d disp=%0d want 1 1 102 102",
                               got, cap_s, cap_amt, last_disp); end
    endtask

    task automatic test_lockout();
        bit got;
        int e0;
        for (int i = 0; i < MAXF; i++) begin
            run_session(2, 1, 0, 50, 0, 77, got);
            checks++; if (!got || last_ok !== 1'b0 || last_disp !== 10'd77) begin
                errors++; $display("FAIL t4_fail%0d: got done=%0b ok=%0b disp=%0d want 1 0 77",
                                   i, got, last_ok, last_disp); end
            checks++; if (locked !== (i == MAXF - 1)) begin
                errors++; $display("FAIL t4_lock%0d: got %0b want %0b", i, locked, i == MAXF - 1); end
        end
        e0 = err_cnt;
        press(K_ENT);
        press(4'd1);
        checks++; if (busy !== 1'b0 || locked !== 1'b1 || err_cnt != e0) begin
            errors++; $display("FAIL t4_ignored: got busy=%0b locked=%0b errs=%0d want 0 1 0",
                               busy, locked, err_cnt - e0); end
        do_reset();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL t4_unlock: got %0b want 0", locked); end
    endtask

    task automatic test_timeout_cancel();
        int t0;
        int e0;
        int first;
        t0 = tmo_cnt;
        e0 = err_cnt;
        first = -1;
        press(K_ENT); press(4'd2); press(K_ENT);
        press(4'd5); press(K_ENT);
        press(4'd3);
        for (int j = 1; j <= TMO + 4; j++) begin
            step();
            if (first < 0 && tmo_cnt > t0) first = j;
        end
        checks++; if (first < TMO - 1 || first > TMO + 3) begin
            errors++; $display("FAIL t5_tmo_window: got cycle %0d want %0d..%0d", first, TMO - 1, TMO + 3); end
        checks++; if (tmo_cnt - t0 != 1 || err_cnt != e0) begin
            errors++; $display("FAIL t5_tmo_pulse: got tmo=%0d errs=%0d want 1 0", tmo_cnt - t0, err_cnt - e0); end
        checks++; if (busy !== 1'b0 || disp_value !== '0 || atm_acc_s !== '0 || atm_select !== '0) begin
            errors++; $display("FAIL t5_tmo_clear: got busy=%0b disp=%0d s=%0d sel=%0d want 0",
                               busy, disp_value, atm_acc_s, atm_select); end
        press(K_ENT); press(4'd3); press(K_ENT);
        press(4'd5); press(K_ENT);
        press(4'd7);
        press(K_CAN);
        checks++; if (busy !== 1'b0 || err_cnt != e0 || atm_acc_s !== '0 || tmo_cnt - t0 != 1) begin
            errors++; $display("FAIL t5_cancel: got busy=%0b errs=%0d s=%0d tmo=%0d want 0 0 0 1",
                               busy, err_cnt - e0, atm_acc_s, tmo_cnt - t0); end
    endtask

    task automatic test_exit_and_abort();
        bit got;
        bit seen;
        int r0;
        int base;
        r0 = req_cyc;
        run_session(0, 0, 0, 0, 0, 0, got);
        checks++; if (!got || last_ok !== 1'b1 || req_cyc != r0 || busy !== 1'b0) begin
            errors++; $display("FAIL t6_exit: got done=%0b ok=%0b reqs=%0d busy=%0b want 1 1 0 0",
                               got, last_ok, req_cyc - r0, busy); end
        atm_result = 2'd3;
        press(K_ENT); press(4'd2); press(K_ENT);
        press(4'd1); press(K_ENT);
        press(4'd9);
        key_valid = 1'b1; key_code = K_ENT; step(); key_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (atm_req) seen = 1'b1; else step();
        end
        checks++; if (!seen) begin errors++; $display("FAIL t6_req_rise: got none want atm_req"); end
        step();
        base = done_cnt;
        rst = 1'b1;
        step();
        checks++; if (atm_req !== 1'b0) begin errors++; $display("FAIL t6_rst_req: got %0b want 0", atm_req); end
        rst = 1'b0;
        repeat (12) step();
        checks++; if (done_cnt != base || busy !== 1'b0) begin
            errors++; $display("FAIL t6_rst_nodone: got dones=%0d busy=%0b want 0 0", done_cnt - base, busy); end
    endtask

    task automatic test_random();
        bit got;
        int mfail;
        int sel, src, dst, amt, res, bal;
        bit exp_ok;
        logic [AMT_W:0] exp;
        mfail = 0;
        for (int n = 0; n < 24; n++) begin
            sel = $urandom_range(2, 3);
            src = $urandom_range(0, 15);
            dst = $urandom_range(0, 15);
            amt = $urandom_range(0, 1023);
            res = ($urandom_range(0, 1) == 1) ? 3 : $urandom_range(0, 2);
            bal = $urandom_range(0, 1023);
            exp_ok = (res == 3);
            exp_q.push_back({exp_ok, exp_ok ? AMT_W'(amt) : AMT_W'(bal)});
            mfail = exp_ok ? 0 : ((mfail < MAXF) ? mfail + 1 : MAXF);
            run_session(sel, src, dst, amt, res, bal, got);
            exp = exp_q.pop_front();
            checks++; if (!got || {last_ok, last_disp} !== exp) begin
                errors++; $display("FAIL rnd%0d_outcome: got done=%0b ok=%0b disp=%0d want ok=%0b disp=%0d",
                                   n, got, last_ok, last_disp, exp[AMT_W], exp[AMT_W-1:0]); end
            checks++; if (cap_sel !== 2'(sel) || cap_s !== 4'(src) || cap_amt !== 10'(amt) ||
                          (sel == 3 && cap_d !== 4'(dst))) begin
                errors++; $display("FAIL rnd%0d_fields: got sel=%0d s=%0d d=%0d amt=%0d want %0d %0d %0d %0d",
                                   n, cap_sel, cap_s, cap_d, cap_amt, sel, src, dst, amt); end
            checks++; if (locked !== (mfail == MAXF)) begin
                errors++; $display("FAIL rnd%0d_lock: got %0b want %0b", n, locked, mfail == MAXF); end
            if (mfail == MAXF) begin
                do_reset();
                mfail = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_balance();
        test_transfer();
        test_entry_errors();
        test_lockout();
        test_timeout_cancel();
        test_exit_and_abort();
        test_random();
        checks++; if (unstable != 0) begin errors++; $display("FAIL req_stable: got %0d changes want 0", unstable); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL err_tmo_overlap: got %0d want 0", overlap); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
